proc_sequencer: RTL and testbench
=================================

// Module: proc_sequencer
// PURPOSE
//  Multi-cycle instruction sequencer for the 16-bit processor datapath (R0-R7, A, R, ALU, bus mux).
//  Accepts one instruction per run/ready handshake and latches it into an internal IR.
//  Steps a T1..T3 state machine that drives mux_select, register write enables, A/R enables and alu_op.
//  Pulses done in the last step. Replaces the free-running step counter plus control decode.
// PARAMETERS
//  DATA_W   16  instruction / bus width
//  IMM_W    10  immediate field width (IR[9:0]), sign-extended outside this block
//  CNT_W    16  width of instr_count
// PORTS
//  clk                input   1       rising-edge clock
//  resetn             input   1       synchronous reset, active-low
//  run                input   1       instruction valid; accepted when run & ready at a clk edge
//  iin                input   DATA_W  instruction: [15:13] opcode, [12:10] Rx, [9:7] Ry, [9:0] imm
//  ready              output  1       sequencer idle, will accept iin this cycle
//  done               output  1       1-cycle pulse, last step of the current instruction
//  illegal            output  1       with done: current opcode undefined, no state changed
//  mux_select         output  4       bus source: 0-7 = R0-R7, 8 = IMM, 9 = R reg, 15 = IDLE
//  regs_write_enable  output  8       one-hot write enable for R0-R7, loaded from the bus
//  alu_op             output  2       00 add, 01 sub, 10 and, 11 pass-B
//  reg_A_enable       output  1       load A from bus
//  reg_R_enable       output  1       load R from ALU result
//  imm_field          output  IMM_W   IR[9:0] of the latched instruction
//  instr_count        output  CNT_W   completed instructions (legal and illegal)
// BEHAVIOUR
//  States: IDLE, T1, T2, T3. All control outputs are decoded combinationally from the registered state and IR.
//  Reset (resetn low at an edge): state=IDLE, IR=0, instr_count=0.
//   While resetn is low, outputs are forced to idle values: ready=1 only after reset is released.
//   done=0, illegal=0, mux_select=15, regs_write_enable=0, alu_op=00, reg_A/R_enable=0.
//  IDLE: ready=1, all other outputs at idle values.
//   On run=1: IR<=iin, go to T1. When run=0, stay in IDLE.
//  Opcodes:
//   000 mv  Rx,Ry
//   001 mvi Rx,#imm
//   010 add
//   011 sub
//   100 and
//   101-111 illegal
//  mv:  T1 sel=Ry, we[Rx]=1, done -> IDLE (1 step).
//  mvi: T1 sel=8 (IMM), we[Rx]=1, done -> IDLE (1 step).
//  add/sub/and (3 steps):
//   T1 sel=Rx, reg_A_enable=1 -> T2.
//   T2 sel=Ry, alu_op=00/01/10, reg_R_enable=1 -> T3.
//   T3 sel=9 (R reg), we[Rx]=1, done -> IDLE.
//  Illegal opcode: T1 done=1, illegal=1, no enables asserted -> IDLE.
//  Latency from accept edge to done: 1 cycle for mv/mvi/illegal, 3 cycles for ALU ops.
//   Throughput: accept, then busy until done, then 1 IDLE cycle before the next accept.
//  ready is 0 in T1-T3 (including the done cycle). run while busy is ignored; iin changes while busy have no effect.
//  Rx==Ry is legal. mv R3,R3 rewrites R3 with itself. add R2,R2 yields 2*R2.
//  regs_write_enable is never multi-hot. At most one of reg_A_enable / reg_R_enable / any we is set per cycle.
//  instr_count increments at the edge leaving the done state and wraps 2^CNT_W-1 -> 0.
//  Reset mid-instruction: abort at that edge -> IDLE. No later step fires; instr_count does not increment.
// STRUCTURE
//  Shared package proc_pkg:
//   opcode constants OP_MV..OP_AND
//   mux select constants SEL_R0..SEL_R7, SEL_IMM=8, SEL_RREG=9, SEL_IDLE=15
//   ALU_ADD/SUB/AND/PASS
//   state encoding
//  Sub-module proc_decoder (combinational): IR -> {op class, illegal, Rx one-hot, Ry index, alu_op}.
//  Top: state register, IR register, instr_count, per-state output decode.
// TESTING
//  Reset, then idle: after a resetn=0 edge, release; check ready=1, mux_select=15, all enables 0, instr_count=0.
//  mvi: run with iin=16'h25F6 (mvi R1,#0x1F6).
//   Next cycle: sel=8, we=8'h02, done=1, imm_field=10'h1F6. ready=1 after that.
//  add: run with iin=16'h4D00 (add R3,R2).
//   T1 sel=3, A_en. T2 sel=2, alu_op=00, R_en. T3 sel=9, we=8'h08, done. instr_count +1.
//  Illegal and busy: run with iin=16'hA000.
//   T1 done=1, illegal=1, we=0.
//   Also hold run=1 with varying iin during a sub: only the first iin is executed.
//  Reset mid-op: drop resetn in T2 of a sub. Next cycle IDLE, no we/R_en pulse, instr_count unchanged.
//  Wrap: 65536 mv instructions -> instr_count returns to 0. Enables are checked one-hot on every cycle.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared constants for the processor sequencer: opcodes, bus mux selects,
// ALU operations, sequencer state encoding and decoded instruction classes.
package proc_pkg;

    localparam logic [2:0] OP_MV  = 3'd0;
    localparam logic [2:0] OP_MVI = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;

    localparam logic [3:0] SEL_R0   = 4'd0;
    localparam logic [3:0] SEL_R1   = 4'd1;
    localparam logic [3:0] SEL_R2   = 4'd2;
    localparam logic [3:0] SEL_R3   = 4'd3;
    localparam logic [3:0] SEL_R4   = 4'd4;
    localparam logic [3:0] SEL_R5   = 4'd5;
    localparam logic [3:0] SEL_R6   = 4'd6;
    localparam logic [3:0] SEL_R7   = 4'd7;
    localparam logic [3:0] SEL_IMM  = 4'd8;
    localparam logic [3:0] SEL_RREG = 4'd9;
    localparam logic [3:0] SEL_IDLE = 4'd15;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_PASS = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_T1   = 2'd1;
    localparam logic [1:0] ST_T2   = 2'd2;
    localparam logic [1:0] ST_T3   = 2'd3;

    typedef enum logic [1:0] {
        CLS_MOVE    = 2'd0,
        CLS_MOVI    = 2'd1,
        CLS_ALU     = 2'd2,
        CLS_ILLEGAL = 2'd3
    } op_class_e;

    function automatic logic [7:0] reg_onehot(input logic [2:0] idx);
        reg_onehot = 8'd1 << idx;
    endfunction

endpackage

// File: rtl/proc_decoder.sv
// Combinational instruction decode: splits the latched IR into its class,
// destination write strobe, source index and the ALU operation for step T2.
module proc_decoder
    import proc_pkg::*;
(
    input  logic [15:7] ir_ctrl,
    output logic [1:0]  op_class,
    output logic        illegal,
    output logic [2:0]  rx_idx,
    output logic [7:0]  rx_onehot,
    output logic [2:0]  ry_idx,
    output logic [1:0]  alu_op
);

    logic [2:0] opcode;

    assign opcode    = ir_ctrl[15:13];
    assign rx_idx    = ir_ctrl[12:10];
    assign ry_idx    = ir_ctrl[9:7];
    assign rx_onehot = reg_onehot(ir_ctrl[12:10]);

    always_comb begin
        op_class = CLS_ILLEGAL;
        illegal  = 1'b1;
        alu_op   = ALU_PASS;
        case (opcode)
            OP_MV: begin
                op_class = CLS_MOVE;
                illegal  = 1'b0;
            end
            OP_MVI: begin
                op_class = CLS_MOVI;
                illegal  = 1'b0;
            end
            OP_ADD: begin
                op_class = CLS_ALU;
                illegal  = 1'b0;
                alu_op   = ALU_ADD;
            end
            OP_SUB: begin
                op_class = CLS_ALU;
                illegal  = 1'b0;
                alu_op   = ALU_SUB;
            end
            OP_AND: begin
                op_class = CLS_ALU;
                illegal  = 1'b0;
                alu_op   = ALU_AND;
            end
            default: begin
                op_class = CLS_ILLEGAL;
                illegal  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/proc_sequencer.sv
// Multi-cycle instruction sequencer: latches one instruction per run/ready
// handshake and steps T1..T3, driving bus select and register enables.
module proc_sequencer
    import proc_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IMM_W  = 10,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              run,
    input  logic [DATA_W-1:0] iin,
    output logic              ready,
    output logic              done,
    output logic              illegal,
    output logic [3:0]        mux_select,
    output logic [7:0]        regs_write_enable,
    output logic [1:0]        alu_op,
    output logic              reg_A_enable,
    output logic              reg_R_enable,
    output logic [IMM_W-1:0]  imm_field,
    output logic [CNT_W-1:0]  instr_count
);

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [1:0] dec_class;
    logic       dec_illegal;
    logic [2:0] dec_rx;
    logic [7:0] dec_rx_onehot;
    logic [2:0] dec_ry;
    logic [1:0] dec_alu_op;

    proc_decoder u_decoder (
        .ir_ctrl   (ir_q[15:7]),
        .op_class  (dec_class),
        .illegal   (dec_illegal),
        .rx_idx    (dec_rx),
        .rx_onehot (dec_rx_onehot),
        .ry_idx    (dec_ry),
        .alu_op    (dec_alu_op)
    );

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    ir_d    = iin;
                    state_d = ST_T1;
                end
            end
            ST_T1:   state_d = (dec_class == CLS_ALU) ? ST_T2 : ST_IDLE;
            ST_T2:   state_d = ST_T3;
            default: state_d = ST_IDLE;
        endcase
        if (done) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            ir_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            count_q <= count_d;
        end
    end

    // Controls are held at idle values whenever resetn is low, even mid-instruction.
    always_comb begin
        ready             = 1'b0;
        done              = 1'b0;
        illegal           = 1'b0;
        mux_select        = SEL_IDLE;
        regs_write_enable = 8'd0;
        alu_op            = ALU_ADD;
        reg_A_enable      = 1'b0;
        reg_R_enable      = 1'b0;
        if (resetn) begin
            case (state_q)
                ST_IDLE: ready = 1'b1;
                ST_T1: begin
                    case (dec_class)
                        CLS_MOVE: begin
                            mux_select        = {1'b0, dec_ry};
                            regs_write_enable = dec_rx_onehot;
                            done              = 1'b1;
                        end
                        CLS_MOVI: begin
                            mux_select        = SEL_IMM;
                            regs_write_enable = dec_rx_onehot;
                            done              = 1'b1;
                        end
                        CLS_ALU: begin
                            mux_select   = {1'b0, dec_rx};
                            reg_A_enable = 1'b1;
                        end
                        default: begin
                            done    = 1'b1;
                            illegal = dec_illegal;
                        end
                    endcase
                end
                ST_T2: begin
                    mux_select   = {1'b0, dec_ry};
                    alu_op       = dec_alu_op;
                    reg_R_enable = 1'b1;
                end
                default: begin
                    mux_select        = SEL_RREG;
                    regs_write_enable = dec_rx_onehot;
                    done              = 1'b1;
                end
            endcase
        end
    end

    assign imm_field   = ir_q[IMM_W-1:0];
    assign instr_count = count_q;

endmodule

// File: tb/tb_proc_sequencer.sv
// Self-checking bench for proc_sequencer: directed vector table, reset and
// busy corner cases, randomized run against a step-list model, counter wrap.
module tb_proc_sequencer;

    typedef struct packed {
        logic        ready;
        logic        done;
        logic        illegal;
        logic [3:0]  sel;
        logic [7:0]  we;
        logic [1:0]  alu;
        logic        a_en;
        logic        r_en;
        logic [9:0]  imm;
        logic [15:0] cnt;
    } outs_t;

    typedef struct packed {
        logic        run;
        logic [15:0] iin;
        outs_t       exp;
    } vec_t;

    logic        clk;
    logic        resetn;
    logic        run;
    logic [15:0] iin;
    logic        ready;
    logic        done;
    logic        illegal;
    logic [3:0]  mux_select;
    logic [7:0]  regs_write_enable;
    logic [1:0]  alu_op;
    logic        reg_A_enable;
    logic        reg_R_enable;
    logic [9:0]  imm_field;
    logic [15:0] instr_count;

    // Narrow-counter instance so the wrap can be exercised in few cycles
    logic        resetn2;
    logic        run2;
    logic [15:0] iin2;
    logic        ready2;
    logic        done2;
    logic        illegal2;
    logic [3:0]  mux_select2;
    logic [7:0]  we2;
    logic [1:0]  alu_op2;
    logic        a_en2;
    logic        r_en2;
    logic [9:0]  imm2;
    logic [5:0]  count2;

    int nChecks = 0;
    int nFails  = 0;

    proc_sequencer dut (
        .clk               (clk),
        .resetn            (resetn),
        .run               (run),
        .iin               (iin),
        .ready             (ready),
        .done              (done),
        .illegal           (illegal),
        .mux_select        (mux_select),
        .regs_write_enable (regs_write_enable),
        .alu_op            (alu_op),
        .reg_A_enable      (reg_A_enable),
        .reg_R_enable      (reg_R_enable),
        .imm_field         (imm_field),
        .instr_count       (instr_count)
    );

    proc_sequencer #(.CNT_W(6)) dut_wrap (
        .clk               (clk),
        .resetn            (resetn2),
        .run               (run2),
        .iin               (iin2),
        .ready             (ready2),
        .done              (done2),
        .illegal           (illegal2),
        .mux_select        (mux_select2),
        .regs_write_enable (we2),
        .alu_op            (alu_op2),
        .reg_A_enable      (a_en2),
        .reg_R_enable      (r_en2),
        .imm_field         (imm2),
        .instr_count       (count2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic outs_t idleOuts(input logic [9:0] imm, input logic [15:0] cnt);
        outs_t o;
        o       = '0;
        o.ready = 1'b1;
        o.sel   = 4'd15;
        o.imm   = imm;
        o.cnt   = cnt;
        return o;
    endfunction

    function automatic outs_t resetOuts();
        outs_t o;
        o       = idleOuts(10'd0, 16'd0);
        o.ready = 1'b0;
        return o;
    endfunction

    function automatic outs_t busyOuts(input logic [3:0] sel, input logic [7:0] we,
                                       input logic [1:0] alu, input logic a, input logic r,
                                       input logic dn, input logic il,
                                       input logic [9:0] imm, input logic [15:0] cnt);
        outs_t o;
        o.ready   = 1'b0;
        o.done    = dn;
        o.illegal = il;
        o.sel     = sel;
        o.we      = we;
        o.alu     = alu;
        o.a_en    = a;
        o.r_en    = r;
        o.imm     = imm;
        o.cnt     = cnt;
        return o;
    endfunction

    function automatic vec_t mkVec(input logic r, input logic [15:0] ins, input outs_t e);
        vec_t v;
        v.run = r;
        v.iin = ins;
        v.exp = e;
        return v;
    endfunction

    // Reference model: number of steps and the outputs of each step, from the opcode rules
    function automatic int nSteps(input logic [15:0] ins);
        int op;
        op = int'(ins[15:13]);
        return (op >= 2 && op <= 4) ? 3 : 1;
    endfunction

    function automatic outs_t stepOuts(input logic [15:0] ins, input int step, input logic [15:0] cnt);
        outs_t o;
        int op;
        int rx;
        int ry;
        op      = int'(ins[15:13]);
        rx      = int'(ins[12:10]);
        ry      = int'(ins[9:7]);
        o       = idleOuts(ins[9:0], cnt);
        o.ready = 1'b0;
        if (op > 4) begin
            o.done    = 1'b1;
            o.illegal = 1'b1;
        end else if (op <= 1) begin
            o.sel  = (op == 0) ? 4'(ry) : 4'd8;
            o.we   = 8'(1 << rx);
            o.done = 1'b1;
        end else if (step == 0) begin
            o.sel  = 4'(rx);
            o.a_en = 1'b1;
        end else if (step == 1) begin
            o.sel  = 4'(ry);
            o.alu  = 2'(op - 2);
            o.r_en = 1'b1;
        end else begin
            o.sel  = 4'd9;
            o.we   = 8'(1 << rx);
            o.done = 1'b1;
        end
        return o;
    endfunction

    function automatic outs_t sampleDut();
        outs_t o;
        o.ready   = ready;
        o.done    = done;
        o.illegal = illegal;
        o.sel     = mux_select;
        o.we      = regs_write_enable;
        o.alu     = alu_op;
        o.a_en    = reg_A_enable;
        o.r_en    = reg_R_enable;
        o.imm     = imm_field;
        o.cnt     = instr_count;
        return o;
    endfunction

    task automatic applyStimulus(input logic r, input logic [15:0] ins);
        run = r;
        iin = ins;
    endtask

    task automatic checkOutput(input string name, input outs_t exp);
        outs_t act;
        act = sampleDut();
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %h expected %h (rdy/dn/il/sel/we/alu/a/r/imm/cnt)",
                     name, act, exp);
        end
    endtask

    // Advance one clock, sample 1 time unit later and check the enable exclusivity rule
    task automatic tick();
        int nEn;
        @(posedge clk);
        #1;
        nEn = int'(reg_A_enable) + int'(reg_R_enable) + int'(|regs_write_enable);
        nChecks++;
        if (!$onehot0(regs_write_enable) || nEn > 1) begin
            nFails++;
            $display("[TB] FAIL enable_exclusive: got we=%h a=%0d r=%0d required onehot0 and <=1 enable",
                     regs_write_enable, reg_A_enable, reg_R_enable);
        end
    endtask

    vec_t        vecs[14];
    logic        mBusy;
    int          mStep;
    logic [15:0] mIns;
    logic [15:0] mCnt;
    logic [9:0]  mImm;
    outs_t       mExp;
    logic        rRun;
    logic [15:0] rIin;
    int          nDone;
    logic        prevDone;
    logic        wrapSeen;
    logic [31:0] rnd;

    initial begin
        resetn  = 1'b0;
        resetn2 = 1'b0;
        run2    = 1'b0;
        iin2    = 16'd0;
        applyStimulus(1'b0, 16'd0);

        vecs[0]  = mkVec(1'b1, 16'h25F6, busyOuts(4'd8, 8'h02, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 10'h1F6, 16'd0));
        vecs[1]  = mkVec(1'b0, 16'h0000, idleOuts(10'h1F6, 16'd1));
        vecs[2]  = mkVec(1'b1, 16'h4D00, busyOuts(4'd3, 8'h00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 10'h100, 16'd1));
        vecs[3]  = mkVec(1'b0, 16'h0000, busyOuts(4'd2, 8'h00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 10'h100, 16'd1));
        vecs[4]  = mkVec(1'b0, 16'h0000, busyOuts(4'd9, 8'h08, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 10'h100, 16'd1));
        vecs[5]  = mkVec(1'b0, 16'h0000, idleOuts(10'h100, 16'd2));
        vecs[6]  = mkVec(1'b1, 16'hA000, busyOuts(4'd15, 8'h00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 10'h000, 16'd2));
        vecs[7]  = mkVec(1'b1, 16'h25F6, idleOuts(10'h000, 16'd3));
        vecs[8]  = mkVec(1'b1, 16'h6C80, busyOuts(4'd3, 8'h00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 10'h080, 16'd3));
        vecs[9]  = mkVec(1'b1, 16'h25F6, busyOuts(4'd1, 8'h00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 10'h080, 16'd3));
        vecs[10] = mkVec(1'b1, 16'h0000, busyOuts(4'd9, 8'h08, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 10'h080, 16'd3));
        vecs[11] = mkVec(1'b0, 16'hFFFF, idleOuts(10'h080, 16'd4));
        vecs[12] = mkVec(1'b1, 16'h0D80, busyOuts(4'd3, 8'h08, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 10'h180, 16'd4));
        vecs[13] = mkVec(1'b0, 16'h0000, idleOuts(10'h180, 16'd5));

        tick();
        checkOutput("reset_held", resetOuts());
        resetn = 1'b1;
        #1;
        checkOutput("reset_released_idle", idleOuts(10'd0, 16'd0));

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].run, vecs[i].iin);
            tick();
            checkOutput($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Reset during T2 of a sub must abort with no write or R load afterwards
        applyStimulus(1'b0, 16'd0);
        resetn = 1'b0;
        tick();
        checkOutput("midop_pre_reset", resetOuts());
        resetn = 1'b1;
        applyStimulus(1'b1, 16'h6C80);
        tick();
        checkOutput("midop_T1", busyOuts(4'd3, 8'h00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 10'h080, 16'd0));
        applyStimulus(1'b0, 16'd0);
        tick();
        checkOutput("midop_T2", busyOuts(4'd1, 8'h00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 10'h080, 16'd0));
        resetn = 1'b0;
        tick();
        checkOutput("midop_reset_edge", resetOuts());
        resetn = 1'b1;
        tick();
        checkOutput("midop_after_release", idleOuts(10'd0, 16'd0));
        tick();
        checkOutput("midop_no_late_step", idleOuts(10'd0, 16'd0));

        mBusy = 1'b0;
        mStep = 0;
        mIns  = 16'd0;
        mCnt  = 16'd0;
        mImm  = 10'd0;
        for (int c = 0; c < 3000; c++) begin
            rRun = ($urandom_range(0, 3) != 0);
            rIin = 16'($urandom);
            applyStimulus(rRun, rIin);
            if (!mBusy) begin
                if (rRun) begin
                    mBusy = 1'b1;
                    mStep = 0;
                    mIns  = rIin;
                    mImm  = rIin[9:0];
                end
            end else if (mStep == nSteps(mIns) - 1) begin
                mBusy = 1'b0;
                mCnt  = mCnt + 16'd1;
            end else begin
                mStep = mStep + 1;
            end
            tick();
            mExp = mBusy ? stepOuts(mIns, mStep, mCnt) : idleOuts(mImm, mCnt);
            checkOutput($sformatf("random_cycle%0d", c), mExp);
        end
        applyStimulus(1'b0, 16'd0);

        // Back-to-back mv on the 6-bit counter instance: 64 completions wrap to 0
        resetn2  = 1'b1;
        run2     = 1'b1;
        nDone    = 0;
        prevDone = 1'b0;
        wrapSeen = 1'b0;
        for (int c = 0; c < 400 && !wrapSeen; c++) begin
            rnd  = $urandom;
            iin2 = {3'b000, rnd[12:0]};
            tick();
            if (prevDone) begin
                nDone++;
                if (nDone == 63) begin
                    nChecks++;
                    if (count2 !== 6'd63) begin
                        nFails++;
                        $display("[TB] FAIL wrap_count_max: got %0d expected 63", count2);
                    end
                end else if (nDone == 64) begin
                    wrapSeen = 1'b1;
                    nChecks++;
                    if (count2 !== 6'd0) begin
                        nFails++;
                        $display("[TB] FAIL wrap_count_zero: got %0d expected 0", count2);
                    end
                end
            end
            prevDone = done2;
        end
        if (!wrapSeen) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL wrap_timeout: got %0d completions expected 64 within 400 cycles", nDone);
        end
        run2 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
